// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the encoder, the decoder and their benches.
// Functions work at GRAY_MAX_W bits; callers zero-extend and truncate to their own width.
package gray_pkg;
    localparam int GRAY_FIFO_DEPTH = 2;
    localparam int GRAY_MAX_W      = 64;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // MSB-first XOR chain; zero upper bits from extension do not disturb the result.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int k = GRAY_MAX_W-2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction
endpackage

// File: rtl/bin2gray_stream_if.sv
// Valid/ready word stream; master drives valid/data, slave drives ready.
interface bin2gray_stream_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gray_fifo2.sv
// Two-entry in-order FIFO; head entry is always presented on dout_o.
module gray_fifo2
    import gray_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   level_o
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   level_q, level_d, after_pop;
    logic         do_push, do_pop;

    assign do_push   = push_i && (level_q != 2'(GRAY_FIFO_DEPTH));
    assign do_pop    = pop_i && (level_q != 2'd0);
    assign after_pop = level_q - 2'(do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = after_pop + 2'(do_push);
        if (do_pop) begin
            head_d = tail_q;
        end
        // The new word lands in whichever slot is first free once the pop is applied.
        if (do_push) begin
            if (after_pop == 2'd0) head_d = din_i;
            else                   tail_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    assign dout_o  = head_q;
    assign valid_o = (level_q != 2'd0);
    assign level_o = level_q;
endmodule

// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with an optional free-running counter source.
// W must not exceed gray_pkg::GRAY_MAX_W.
module bin2gray_stream
    import gray_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    bin2gray_stream_if.slave  in_s,
    bin2gray_stream_if.master out_m,
    input  logic             src_gen,
    input  logic             gen_load,
    input  logic [W-1:0]     gen_value,
    output logic [1:0]       level
);
    logic [W-1:0] cnt_q, cnt_d, src_bin, push_gray, fifo_dout;
    logic         full, push, pop, fifo_valid;
    logic [1:0]   fifo_level;

    assign full       = (fifo_level == 2'(GRAY_FIFO_DEPTH));
    assign in_s.ready = !rst && !src_gen && !full;
    assign pop        = fifo_valid && out_m.ready;

    always_comb begin
        push  = src_gen ? (!full && !gen_load) : (in_s.valid && in_s.ready);
        cnt_d = cnt_q;
        if (gen_load) begin
            cnt_d = gen_value;
        end else if (src_gen && push) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign src_bin   = src_gen ? cnt_q : in_s.data;
    assign push_gray = W'(bin2gray(GRAY_MAX_W'(src_bin)));

    gray_fifo2 #(.W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_gray),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .valid_o (fifo_valid),
        .level_o (fifo_level)
    );

    assign out_m.data  = fifo_dout;
    assign out_m.valid = fifo_valid;
    assign level       = fifo_level;
endmodule

// File: tb/tb_bin2gray_stream.sv
// Scenario bench for bin2gray_stream: directed vectors, backpressure, generator, wrap, reset, random round-trip.
module tb_bin2gray_stream;
    import gray_pkg::*;

    logic        clk;
    logic        rst;
    logic        src_gen;
    logic        gen_load;
    logic [31:0] gen_value;
    logic [1:0]  level;
    int          tests;
    int          fails;

    bin2gray_stream_if #(.W(32)) in_if ();
    bin2gray_stream_if #(.W(32)) out_if ();

    bin2gray_stream #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_s      (in_if),
        .out_m     (out_if),
        .src_gen   (src_gen),
        .gen_load  (gen_load),
        .gen_value (gen_value),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_if.valid = 1'b1; in_if.data = 32'h5; out_if.ready = 1'b0;
        @(negedge clk); #1;
        tests++; if (out_if.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
        tests++; if (out_if.data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", out_if.data); end
        tests++; if (level !== 2'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
        tests++; if (in_if.ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_if.ready); end
        @(negedge clk);
        rst = 1'b0; in_if.valid = 1'b0;
        #1;
        tests++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b expected 1", in_if.ready); end
    endtask

    task automatic test_vectors();
        logic [31:0] vin [3];
        logic [31:0] vexp [3];
        vin[0] = 32'h0000000B; vexp[0] = 32'h0000000E;
        vin[1] = 32'hFFFFFFFF; vexp[1] = 32'h80000000;
        vin[2] = 32'h80000000; vexp[2] = 32'hC0000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_if.valid = 1'b1; in_if.data = vin[i]; out_if.ready = 1'b1;
            #1;
            tests++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_if.ready); end
            @(negedge clk);
            in_if.valid = 1'b0;
            #1;
            tests++;
            if (out_if.valid !== 1'b1 || out_if.data !== vexp[i]) begin
                fails++; $display("FAIL vec%0d_out: got v=%b d=%h expected v=1 d=%h", i, out_if.valid, out_if.data, vexp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.data = 32'd1; #1;
        tests++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL bp_c1_ready: got %b expected 1", in_if.ready); end
        @(negedge clk);
        in_if.data = 32'd2; #1;
        tests++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL bp_c2_ready: got %b expected 1", in_if.ready); end
        @(negedge clk);
        in_if.data = 32'd3; #1;
        tests++; if (in_if.ready !== 1'b0) begin fails++; $display("FAIL bp_c3_ready: got %b expected 0", in_if.ready); end
        tests++; if (level !== 2'd2) begin fails++; $display("FAIL bp_c3_level: got %0d expected 2", level); end
        @(negedge clk);
        out_if.ready = 1'b1; #1;
        tests++; if (in_if.ready !== 1'b0) begin fails++; $display("FAIL bp_full_pop_ready: got %b expected 0", in_if.ready); end
        tests++; if (out_if.data !== 32'h1) begin fails++; $display("FAIL bp_out1: got %h expected 1", out_if.data); end
        @(negedge clk); #1;
        tests++; if (level !== 2'd1 || out_if.data !== 32'h3) begin fails++; $display("FAIL bp_out2: got l=%0d d=%h expected l=1 d=3", level, out_if.data); end
        tests++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL bp_c5_ready: got %b expected 1", in_if.ready); end
        @(negedge clk);
        in_if.valid = 1'b0; #1;
        tests++; if (level !== 2'd1 || out_if.data !== 32'h2) begin fails++; $display("FAIL bp_out3: got l=%0d d=%h expected l=1 d=2", level, out_if.data); end
        @(negedge clk); #1;
        tests++; if (level !== 2'd0) begin fails++; $display("FAIL bp_drained: got %0d expected 0", level); end
    endtask

    task automatic test_generator();
        logic [31:0] exp_seq [8];
        logic [31:0] prev;
        exp_seq[0] = 32'd0; exp_seq[1] = 32'd1; exp_seq[2] = 32'd3; exp_seq[3] = 32'd2;
        exp_seq[4] = 32'd6; exp_seq[5] = 32'd7; exp_seq[6] = 32'd5; exp_seq[7] = 32'd4;
        @(negedge clk);
        rst = 1'b1; src_gen = 1'b1; out_if.ready = 1'b1; #1;
        tests++; if (in_if.ready !== 1'b0) begin fails++; $display("FAIL gen_in_ready: got %b expected 0", in_if.ready); end
        @(negedge clk);
        rst = 1'b0; #1;
        tests++; if (level !== 2'd0 || out_if.valid !== 1'b0) begin fails++; $display("FAIL gen_start: got l=%0d v=%b expected l=0 v=0", level, out_if.valid); end
        prev = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            tests++;
            if (out_if.valid !== 1'b1 || out_if.data !== exp_seq[i]) begin
                fails++; $display("FAIL gen_seq%0d: got v=%b d=%h expected v=1 d=%h", i, out_if.valid, out_if.data, exp_seq[i]);
            end
            if (i > 0) begin
                tests++;
                if ($countones(out_if.data ^ prev) != 1) begin
                    fails++; $display("FAIL gen_onebit%0d: got %h after %h expected one-bit change", i, out_if.data, prev);
                end
            end
            prev = out_if.data;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'h80000001; exp_seq[1] = 32'h80000000;
        exp_seq[2] = 32'h00000000; exp_seq[3] = 32'h00000001;
        @(negedge clk);
        src_gen = 1'b0; in_if.valid = 1'b0;
        @(negedge clk);
        src_gen = 1'b1; gen_load = 1'b1; gen_value = 32'hFFFFFFFE; #1;
        tests++; if (level !== 2'd0) begin fails++; $display("FAIL wrap_drained: got %0d expected 0", level); end
        @(negedge clk);
        gen_load = 1'b0; #1;
        tests++; if (level !== 2'd0) begin fails++; $display("FAIL wrap_load_nopush: got %0d expected 0", level); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            tests++;
            if (out_if.valid !== 1'b1 || out_if.data !== exp_seq[i]) begin
                fails++; $display("FAIL wrap_seq%0d: got v=%b d=%h expected v=1 d=%h", i, out_if.valid, out_if.data, exp_seq[i]);
            end
        end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        out_if.ready = 1'b0;
        @(negedge clk); #1;
        tests++; if (level !== 2'd2) begin fails++; $display("FAIL mr_full: got %0d expected 2", level); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        tests++; if (out_if.valid !== 1'b0 || level !== 2'd0) begin fails++; $display("FAIL mr_cleared: got v=%b l=%0d expected v=0 l=0", out_if.valid, level); end
        @(negedge clk);
        out_if.ready = 1'b1; #1;
        tests++; if (out_if.valid !== 1'b1 || out_if.data !== 32'h0) begin fails++; $display("FAIL mr_first: got v=%b d=%h expected v=1 d=0", out_if.valid, out_if.data); end
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] expw, gotw;
        int acc, ncyc;
        acc = 0; ncyc = 0;
        @(negedge clk);
        src_gen = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        while ((acc < 10000 && ncyc < 40000) || (acc >= 10000 && q.size() != 0 && ncyc < 40010)) begin
            if (acc >= 10000) begin
                in_if.valid = 1'b0; out_if.ready = 1'b1;
            end else begin
                in_if.valid  = ($urandom_range(3) != 0);
                in_if.data   = $urandom;
                out_if.ready = $urandom_range(1) == 1;
            end
            #1;
            tests++;
            if (level !== 2'(q.size())) begin
                fails++; $display("FAIL rnd_level@%0d: got %0d expected %0d", ncyc, level, q.size());
            end
            if (out_if.valid && out_if.ready) begin
                tests++;
                gotw = 32'(gray2bin(64'(out_if.data)));
                if (q.size() == 0) begin
                    fails++; $display("FAIL rnd_spurious@%0d: got %h expected no word", ncyc, gotw);
                end else begin
                    expw = q.pop_front();
                    if (gotw !== expw) begin
                        fails++; $display("FAIL rnd_word@%0d: got %h expected %h", ncyc, gotw, expw);
                    end
                end
            end
            if (in_if.valid && in_if.ready) begin
                q.push_back(in_if.data);
                acc++;
            end
            @(negedge clk);
            ncyc++;
        end
        in_if.valid = 1'b0;
        tests++;
        if (acc != 10000 || q.size() != 0) begin
            fails++; $display("FAIL rnd_complete: got %0d accepted %0d pending expected 10000 accepted 0 pending", acc, q.size());
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; src_gen = 1'b0; gen_load = 1'b0; gen_value = '0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_generator();
        test_wrap();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
